// File: rtl/xadc_select_sequencer_if.sv
// rtl/xadc_select_sequencer_if.sv - button/strobe inputs and mux/display outputs of the XADC select sequencer
interface xadc_select_sequencer_if;
  logic       btn_next;
  logic       btn_prev;
  logic       auto_en;
  logic       sample_valid;
  logic [1:0] data_select;
  logic       display_update;
  logic       mode_busy;

  modport master (
    output btn_next, btn_prev, auto_en, sample_valid,
    input  data_select, display_update, mode_busy
  );

  modport slave (
    input  btn_next, btn_prev, auto_en, sample_valid,
    output data_select, display_update, mode_busy
  );
endinterface

// File: rtl/xadc_select_sequencer.sv
// rtl/xadc_select_sequencer.sv - XADC mux select sequencer: debounced buttons, auto-scroll, blank/settle/active FSM
// Optional XADC_SEQ_SKIP_OFF_EN: rotate only through 01/10/11 so the target never becomes OFF.
module xadc_select_sequencer #(
  parameter int DEBOUNCE_CYCLES    = 1_000_000,
  parameter int BLANK_CYCLES       = 1_000,
  parameter int AUTO_PERIOD_CYCLES = 100_000_000,
  parameter int SETTLE_SAMPLES     = 1
) (
  input  logic clk,
  input  logic reset,
  xadc_select_sequencer_if.slave bus
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW  = $clog2(BLANK_CYCLES + 1);
  localparam int AW  = $clog2(AUTO_PERIOD_CYCLES + 1);
  localparam int SW  = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;

  localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0]  BLANK_LAST  = BW'(BLANK_CYCLES - 1);
  localparam logic [AW-1:0]  AUTO_LAST   = AW'(AUTO_PERIOD_CYCLES - 1);
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]          db_q, db_d, db_dly_q, db_dly_d;
  logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]          target_q, target_d;
  logic [BW-1:0]       blank_cnt_q, blank_cnt_d;
  logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
  logic [AW-1:0]       auto_cnt_q, auto_cnt_d;
  logic [1:0]          sel_q, sel_d;
  logic                upd_q, upd_d;
  logic                busy_q, busy_d;

  logic [1:0] rise;
  logic       btn_one, auto_fire, go_next, go_prev, mode_evt;

  function automatic logic [1:0] rot_next(input logic [1:0] t);
`ifdef XADC_SEQ_SKIP_OFF_EN
    return (t == 2'b11) ? 2'b01 : t + 2'd1;
`else
    return t + 2'd1;
`endif
  endfunction

  function automatic logic [1:0] rot_prev(input logic [1:0] t);
`ifdef XADC_SEQ_SKIP_OFF_EN
    return (t == 2'b01) ? 2'b11 : t - 2'd1;
`else
    return t - 2'd1;
`endif
  endfunction

  // bit 0 = next, bit 1 = prev; simultaneous rises cancel, a lone rise beats auto-advance
  assign rise      = db_q & ~db_dly_q;
  assign btn_one   = rise[0] ^ rise[1];
  assign auto_fire = (state_q == ST_ACTIVE) && bus.auto_en && (auto_cnt_q == AUTO_LAST);
  assign go_next   = btn_one ? rise[0] : auto_fire;
  assign go_prev   = btn_one & rise[1];
  assign mode_evt  = go_next | go_prev;

  always_comb begin
    state_d      = state_q;
    sync1_d      = {bus.btn_prev, bus.btn_next};
    sync2_d      = sync1_q;
    db_d         = db_q;
    db_dly_d     = db_q;
    db_cnt_d     = db_cnt_q;
    target_d     = target_q;
    blank_cnt_d  = blank_cnt_q;
    settle_cnt_d = settle_cnt_q;
    auto_cnt_d   = '0;

    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i]     = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end

    if ((state_q == ST_ACTIVE) && bus.auto_en)
      auto_cnt_d = auto_fire ? '0 : auto_cnt_q + 1'b1;

    case (state_q)
      ST_BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          blank_cnt_d  = '0;
          settle_cnt_d = '0;
          state_d      = (SETTLE_SAMPLES == 0) ? ST_ACTIVE : ST_SETTLE;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (bus.sample_valid) begin
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_d = '0;
            state_d      = ST_ACTIVE;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
      end
      ST_ACTIVE: ;
      default: state_d = ST_BLANK;
    endcase

    if (mode_evt) begin
      target_d     = go_next ? rot_next(target_q) : rot_prev(target_q);
      state_d      = ST_BLANK;
      blank_cnt_d  = '0;
      settle_cnt_d = '0;
      auto_cnt_d   = '0;
    end

    // outputs are registered from the next state so they line up with state_q
    upd_d  = (state_q == ST_ACTIVE) && bus.sample_valid && !mode_evt;
    sel_d  = (state_d == ST_BLANK) ? 2'b00 : target_d;
    busy_d = (state_d != ST_ACTIVE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_q         <= '0;
      db_dly_q     <= '0;
      db_cnt_q     <= '0;
      target_q     <= 2'b01;
      blank_cnt_q  <= '0;
      settle_cnt_q <= '0;
      auto_cnt_q   <= '0;
      sel_q        <= 2'b00;
      upd_q        <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_q         <= db_d;
      db_dly_q     <= db_dly_d;
      db_cnt_q     <= db_cnt_d;
      target_q     <= target_d;
      blank_cnt_q  <= blank_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      auto_cnt_q   <= auto_cnt_d;
      sel_q        <= sel_d;
      upd_q        <= upd_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.data_select    = sel_q;
  assign bus.display_update = upd_q;
  assign bus.mode_busy      = busy_q;

endmodule
